// File: rtl/cpu_pkg.sv
// Shared ISA encodings and control types for the decode stage and its controller.
package cpu_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_ADDI = 5'd5,
    OP_LDI  = 5'd6,
    OP_LD   = 5'd7,
    OP_ST   = 5'd8,
    OP_PUSH = 5'd9,
    OP_POP  = 5'd10,
    OP_CMP  = 5'd11,
    OP_JMP  = 5'd12,
    OP_BR   = 5'd13,
    OP_CALL = 5'd14,
    OP_RET  = 5'd15
  } opcode_t;

  typedef enum logic [1:0] {
    IMM_16 = 2'b00,
    IMM_19 = 2'b01,
    IMM_27 = 2'b10
  } imm_sel_t;

  typedef enum logic [1:0] {
    DST_RS1 = 2'b00,
    DST_RS2 = 2'b01,
    DST_RD3 = 2'b10
  } reg_dst_sel_t;

  typedef struct packed {
    logic cmp;
    logic returni;
    logic mem_addr_sel;
    logic sp_sel;
    logic mem_wr;
    logic wb_sel;
    logic reg_wr;
    logic call;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control bundle, immediate/destination selects
// and branch redirect controls. Unlisted opcodes decode as a no-op.
module decode_ctrl
  import cpu_pkg::*;
(
  input  opcode_t      opcode,
  output ctrl_t        ctrl,
  output imm_sel_t     imm_sel,
  output reg_dst_sel_t reg_dst_sel,
  output logic         branch_type,
  output logic         branch_sel
);

  always_comb begin
    ctrl        = '0;
    imm_sel     = IMM_16;
    reg_dst_sel = DST_RD3;
    branch_type = 1'b0;
    branch_sel  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: ctrl.reg_wr = 1'b1;
      OP_ADDI, OP_LDI: begin
        ctrl.reg_wr = 1'b1;
        imm_sel     = IMM_19;
        reg_dst_sel = DST_RS1;
      end
      OP_LD: begin
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = 1'b1;
        reg_dst_sel = DST_RS2;
      end
      OP_ST: ctrl.mem_wr = 1'b1;
      OP_PUSH: begin
        ctrl.mem_wr       = 1'b1;
        ctrl.sp_sel       = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
      end
      OP_POP: begin
        ctrl.reg_wr       = 1'b1;
        ctrl.wb_sel       = 1'b1;
        ctrl.sp_sel       = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
      end
      OP_CMP: ctrl.cmp = 1'b1;
      OP_JMP: begin
        imm_sel    = IMM_27;
        branch_sel = 1'b1;
      end
      OP_BR: begin
        imm_sel     = IMM_27;
        branch_sel  = 1'b1;
        branch_type = 1'b1;
      end
      // Call redirects PC-relative and pushes the return address.
      OP_CALL: begin
        imm_sel           = IMM_27;
        branch_sel        = 1'b1;
        branch_type       = 1'b1;
        ctrl.call         = 1'b1;
        ctrl.mem_wr       = 1'b1;
        ctrl.sp_sel       = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
      end
      OP_RET: begin
        ctrl.returni      = 1'b1;
        ctrl.sp_sel       = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with register file, WB->ID bypass, load-use stall and registered ID/EX boundary.
// Optional feature: define STALL_CNT_EN to build the saturating load-use stall counter.
module decode_stage_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_WR_PORTS = 1,
  parameter int NUM_REGS     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_valid,
  output logic                           id_ready,
  input  logic [31:0]                    instr,
  input  logic [31:0]                    pc_plus_4,
  input  logic                           interrupt,
  input  logic [NUM_WR_PORTS-1:0]        wr,
  input  logic [REG_AW*NUM_WR_PORTS-1:0] wr_dst,
  input  logic [DATA_W*NUM_WR_PORTS-1:0] wr_data,
  input  logic                           flush,
  input  logic                           ex_ready,
  output logic                           ex_valid,
  output logic [DATA_W-1:0]              ex_rd1,
  output logic [DATA_W-1:0]              ex_rd2,
  output logic [DATA_W-1:0]              ex_imm,
  output logic [REG_AW-1:0]              ex_reg_dst,
  output logic [REG_AW-1:0]              ex_rs1,
  output logic [REG_AW-1:0]              ex_rs2,
  output logic [31:0]                    ex_pc_plus_4,
  output logic                           ex_interrupt,
  output logic [4:0]                     ex_opcode,
  output ctrl_t                          ex_ctrl,
  output logic [31:0]                    branch_pc,
  output logic                           branch_sel,
  output logic [31:0]                    stall_cnt
);

  logic [REG_AW-1:0] rs1, rs2, rd3, reg_dst;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic [DATA_W-1:0] regs [NUM_REGS];
  ctrl_t             ctrl;
  imm_sel_t          imm_sel;
  reg_dst_sel_t      reg_dst_sel;
  logic              branch_type, dec_branch_sel;
  logic              load_use, accept;

  assign rs1 = instr[26:23];
  assign rs2 = instr[22:19];
  assign rd3 = instr[18:15];

  decode_ctrl u_decode_ctrl (
    .opcode      (opcode_t'(instr[31:27])),
    .ctrl        (ctrl),
    .imm_sel     (imm_sel),
    .reg_dst_sel (reg_dst_sel),
    .branch_type (branch_type),
    .branch_sel  (dec_branch_sel)
  );

  always_comb begin
    case (imm_sel)
      IMM_16:  imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
      IMM_19:  imm = {{(DATA_W-19){instr[18]}}, instr[18:0]};
      default: imm = {{(DATA_W-27){instr[26]}}, instr[26:0]};
    endcase
    case (reg_dst_sel)
      DST_RS1: reg_dst = rs1;
      DST_RS2: reg_dst = rs2;
      default: reg_dst = rd3;
    endcase
  end

  // Walk ports high to low so the lowest-index matching writer wins the bypass.
  always_comb begin
    rd1 = regs[rs1];
    rd2 = regs[rs2];
    for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
      if (wr[p] && (wr_dst[p*REG_AW +: REG_AW] == rs1)) rd1 = wr_data[p*DATA_W +: DATA_W];
      if (wr[p] && (wr_dst[p*REG_AW +: REG_AW] == rs2)) rd2 = wr_data[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
        if (wr[p]) regs[wr_dst[p*REG_AW +: REG_AW]] <= wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  assign load_use   = ex_valid && ex_ctrl.reg_wr && ex_ctrl.wb_sel &&
                      ((ex_reg_dst == rs1) || (ex_reg_dst == rs2));
  assign id_ready   = !flush && !load_use && (!ex_valid || ex_ready);
  assign accept     = if_valid && id_ready;
  assign branch_pc  = imm[31:0] + (branch_type ? pc_plus_4 : 32'd0);
  assign branch_sel = accept && dec_branch_sel;

  // Flush only kills the valid bit; payload is reloaded solely on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_reg_dst   <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_pc_plus_4 <= '0;
      ex_interrupt <= 1'b0;
      ex_opcode    <= '0;
      ex_ctrl      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_valid || ex_ready) begin
      ex_valid <= accept;
      if (accept) begin
        ex_rd1       <= rd1;
        ex_rd2       <= rd2;
        ex_imm       <= imm;
        ex_reg_dst   <= reg_dst;
        ex_rs1       <= rs1;
        ex_rs2       <= rs2;
        ex_pc_plus_4 <= pc_plus_4;
        ex_interrupt <= interrupt;
        ex_opcode    <= instr[31:27];
        ex_ctrl      <= ctrl;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (if_valid && load_use && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed literal scenarios plus
// randomized traffic checked every cycle against a table-driven reference model.
module tb_decode_stage_pipe;
  import cpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int NWP    = 2;
`ifdef STALL_CNT_EN
  localparam logic [31:0] EXP_STALL1 = 32'd1;
`else
  localparam logic [31:0] EXP_STALL1 = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_valid, id_ready, interrupt, flush, ex_ready;
  logic [31:0]       instr, pc_plus_4;
  logic [NWP-1:0]    wr;
  logic [4*NWP-1:0]  wr_dst;
  logic [DATA_W*NWP-1:0] wr_data;
  logic              ex_valid, ex_interrupt, branch_sel;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [3:0]        ex_reg_dst, ex_rs1, ex_rs2;
  logic [31:0]       ex_pc_plus_4, branch_pc, stall_cnt;
  logic [4:0]        ex_opcode;
  ctrl_t             ex_ctrl;
  logic [7:0]        ex_ctrl_bits;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  // Decode table entry: {branch_sel, branch_type, imm_sel[1:0], dst_sel[1:0], ctrl[7:0]}
  logic [13:0] dec_tab [32];

  logic [31:0] mregs [16];
  logic        m_valid, m_intr;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc4, m_stall;
  logic [3:0]  m_dst, m_rs1, m_rs2;
  logic [4:0]  m_op;
  logic [7:0]  m_ctrl;

  assign ex_ctrl_bits = ex_ctrl;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(DATA_W), .NUM_WR_PORTS(NWP), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .id_ready(id_ready),
    .instr(instr), .pc_plus_4(pc_plus_4), .interrupt(interrupt),
    .wr(wr), .wr_dst(wr_dst), .wr_data(wr_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_reg_dst(ex_reg_dst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc_plus_4(ex_pc_plus_4), .ex_interrupt(ex_interrupt), .ex_opcode(ex_opcode),
    .ex_ctrl(ex_ctrl), .branch_pc(branch_pc), .branch_sel(branch_sel), .stall_cnt(stall_cnt)
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] d, input logic [14:0] lo);
    return {op, a, b, d, lo};
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] ins);
    logic [1:0] s;
    s = dec_tab[ins[31:27]][11:10];
    if (s == 2'b00) return 32'($signed(ins[15:0]));
    if (s == 2'b01) return 32'($signed(ins[18:0]));
    return 32'($signed(ins[26:0]));
  endfunction

  function automatic logic [3:0] f_dst(input logic [31:0] ins);
    logic [1:0] s;
    s = dec_tab[ins[31:27]][9:8];
    if (s == 2'b00) return ins[26:23];
    if (s == 2'b01) return ins[22:19];
    return ins[18:15];
  endfunction

  function automatic logic f_hit(input logic [3:0] idx);
    for (int p = 0; p < NWP; p++) if (wr[p] && wr_dst[p*4 +: 4] == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Lowest-numbered writer targeting idx.
  function automatic logic [31:0] f_wval(input logic [3:0] idx);
    for (int p = 0; p < NWP; p++) if (wr[p] && wr_dst[p*4 +: 4] == idx) return wr_data[p*32 +: 32];
    return 32'd0;
  endfunction

  function automatic logic [31:0] f_read(input logic [3:0] idx);
    return f_hit(idx) ? f_wval(idx) : mregs[idx];
  endfunction

  function automatic logic m_load_use();
    return m_valid && m_ctrl[1] && m_ctrl[2] && (m_dst == instr[26:23] || m_dst == instr[22:19]);
  endfunction

  function automatic logic m_ready();
    return !flush && !m_load_use() && (!m_valid || ex_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rd1 <= '0; m_rd2 <= '0; m_imm <= '0; m_pc4 <= '0;
      m_dst <= '0; m_rs1 <= '0; m_rs2 <= '0; m_op <= '0; m_ctrl <= '0; m_intr <= 1'b0;
      m_stall <= '0;
      for (int r = 0; r < 16; r++) mregs[r] <= '0;
    end else begin
`ifdef STALL_CNT_EN
      if (if_valid && m_load_use() && !flush && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
`endif
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!m_valid || ex_ready) begin
        m_valid <= if_valid && m_ready();
        if (if_valid && m_ready()) begin
          m_rd1  <= f_read(instr[26:23]);
          m_rd2  <= f_read(instr[22:19]);
          m_imm  <= f_imm(instr);
          m_dst  <= f_dst(instr);
          m_rs1  <= instr[26:23];
          m_rs2  <= instr[22:19];
          m_pc4  <= pc_plus_4;
          m_intr <= interrupt;
          m_op   <= instr[31:27];
          m_ctrl <= dec_tab[instr[31:27]][7:0];
        end
      end
      for (int r = 0; r < 16; r++) if (f_hit(4'(r))) mregs[r] <= f_wval(4'(r));
    end
  end

  task automatic checkOutput();
    logic [13:0] t;
    logic [31:0] bpc;
    t   = dec_tab[instr[31:27]];
    bpc = f_imm(instr) + (t[12] ? pc_plus_4 : 32'd0);
    compare("id_ready",     32'(id_ready),   32'(m_ready()));
    compare("branch_sel",   32'(branch_sel), 32'(if_valid && m_ready() && t[13]));
    compare("branch_pc",    branch_pc,       bpc);
    compare("ex_valid",     32'(ex_valid),   32'(m_valid));
    compare("ex_rd1",       ex_rd1,          m_rd1);
    compare("ex_rd2",       ex_rd2,          m_rd2);
    compare("ex_imm",       ex_imm,          m_imm);
    compare("ex_reg_dst",   32'(ex_reg_dst), 32'(m_dst));
    compare("ex_rs1",       32'(ex_rs1),     32'(m_rs1));
    compare("ex_rs2",       32'(ex_rs2),     32'(m_rs2));
    compare("ex_pc_plus_4", ex_pc_plus_4,    m_pc4);
    compare("ex_interrupt", 32'(ex_interrupt), 32'(m_intr));
    compare("ex_opcode",    32'(ex_opcode),  32'(m_op));
    compare("ex_ctrl",      32'(ex_ctrl_bits), 32'(m_ctrl));
    compare("stall_cnt",    stall_cnt,       m_stall);
  endtask

  always @(negedge clk) if (check_en) checkOutput();

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                               input logic intr, input logic [1:0] w, input logic [7:0] wd,
                               input logic [63:0] wdat, input logic fl, input logic er);
    if_valid = v; instr = ins; pc_plus_4 = pc4; interrupt = intr;
    wr = w; wr_dst = wd; wr_data = wdat; flush = fl; ex_ready = er;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rnd_ins;
  logic [4:0]  rnd_op;
  int          hi;

  initial begin
    for (int i = 0; i < 32; i++) dec_tab[i] = {2'b00, 2'b00, 2'b10, 8'h00};
    for (int i = 1; i <= 4; i++) dec_tab[i] = {2'b00, 2'b00, 2'b10, 8'h02};
    dec_tab[5]  = {2'b00, 2'b01, 2'b00, 8'h02};
    dec_tab[6]  = {2'b00, 2'b01, 2'b00, 8'h02};
    dec_tab[7]  = {2'b00, 2'b00, 2'b01, 8'h06};
    dec_tab[8]  = {2'b00, 2'b00, 2'b10, 8'h08};
    dec_tab[9]  = {2'b00, 2'b00, 2'b10, 8'h38};
    dec_tab[10] = {2'b00, 2'b00, 2'b10, 8'h36};
    dec_tab[11] = {2'b00, 2'b00, 2'b10, 8'h80};
    dec_tab[12] = {2'b10, 2'b10, 2'b10, 8'h00};
    dec_tab[13] = {2'b11, 2'b10, 2'b10, 8'h00};
    dec_tab[14] = {2'b11, 2'b10, 2'b10, 8'h39};
    dec_tab[15] = {2'b00, 2'b00, 2'b10, 8'h70};

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    check_en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    compare("rst_ex_valid", 32'(ex_valid), 32'd0);
    compare("rst_ex_rd1", ex_rd1, 32'd0);
    compare("rst_stall", stall_cnt, 32'd0);

    // Same-cycle bypass on port 0 into rs2.
    applyStimulus(1'b1, mk(5'd1, 4'd0, 4'd5, 4'd1, 15'd0), 32'h10, 1'b0, 2'b01, {4'd0, 4'd5},
                  {32'h0, 32'hA5}, 1'b0, 1'b1);
    cyc();
    compare("t3_rd2", ex_rd2, 32'hA5);
    compare("t3_valid", 32'(ex_valid), 32'd1);

    // Both ports write r7: port 0 must win in bypass and in the regfile.
    applyStimulus(1'b1, mk(5'd1, 4'd7, 4'd0, 4'd2, 15'd0), 32'h14, 1'b0, 2'b11, {4'd7, 4'd7},
                  {32'h22, 32'h11}, 1'b0, 1'b1);
    cyc();
    compare("t4_bypass", ex_rd1, 32'h11);
    applyStimulus(1'b1, mk(5'd1, 4'd7, 4'd0, 4'd2, 15'd0), 32'h18, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    cyc();
    compare("t4_regfile", ex_rd1, 32'h11);

    // Load r3 then a consumer of r3: one bubble, then issue.
    applyStimulus(1'b1, mk(5'd7, 4'd0, 4'd3, 4'd0, 15'd0), 32'h1C, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    cyc();
    compare("t2_ld_dst", 32'(ex_reg_dst), 32'd3);
    applyStimulus(1'b1, mk(5'd1, 4'd3, 4'd0, 4'd4, 15'd0), 32'h20, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    compare("t2_stall_ready", 32'(id_ready), 32'd0);
    cyc();
    compare("t2_bubble", 32'(ex_valid), 32'd0);
    compare("t2_stall_cnt", stall_cnt, EXP_STALL1);
    @(negedge clk);
    compare("t2_ready_again", 32'(id_ready), 32'd1);
    cyc();
    compare("t2_issue_valid", 32'(ex_valid), 32'd1);
    compare("t2_issue_op", 32'(ex_opcode), 32'd1);

    // EX back-pressure for three cycles with a branch waiting in ID.
    applyStimulus(1'b1, mk(5'd5, 4'd2, 4'd6, 4'd9, 15'h1234), 32'h200, 1'b1, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    cyc();
    applyStimulus(1'b1, mk(5'd13, 4'd0, 4'd0, 4'd0, 15'd4), 32'h300, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare("t5_id_ready", 32'(id_ready), 32'd0);
      compare("t5_branch_sel", 32'(branch_sel), 32'd0);
      cyc();
      compare("t5_imm", ex_imm, 32'hFFFC9234);
      compare("t5_pc4", ex_pc_plus_4, 32'h200);
      compare("t5_valid", 32'(ex_valid), 32'd1);
    end

    // Flush kills ID/EX and the incoming instruction; then a PC-relative branch.
    applyStimulus(1'b1, mk(5'd1, 4'd1, 4'd1, 4'd1, 15'd0), 32'h400, 1'b0, 2'b00, 8'h00, 64'd0, 1'b1, 1'b1);
    @(negedge clk);
    compare("t6_flush_ready", 32'(id_ready), 32'd0);
    cyc();
    compare("t6_flush_valid", 32'(ex_valid), 32'd0);
    compare("t6_flush_payload", ex_imm, 32'hFFFC9234);
    applyStimulus(1'b1, {5'd13, 27'h7FFFFF8}, 32'h100, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    compare("t6_branch_pc", branch_pc, 32'hF8);
    compare("t6_branch_sel", 32'(branch_sel), 32'd1);
    cyc();
    compare("t6_imm", ex_imm, 32'hFFFFFFF8);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, mk(5'd1, 4'd1, 4'd2, 4'd3, 15'd0), 32'h500, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    compare("t1_valid", 32'(ex_valid), 32'd0);
    compare("t1_imm", ex_imm, 32'd0);
    compare("t1_pc4", ex_pc_plus_4, 32'd0);
    compare("t1_opcode", 32'(ex_opcode), 32'd0);
    compare("t1_ctrl", 32'(ex_ctrl_bits), 32'd0);
    #1 rst_n = 1'b1;
    cyc();

    for (int c = 0; c < 800; c++) begin
      hi     = ($urandom_range(0, 1) == 0) ? 7 : 15;
      rnd_op = ($urandom_range(0, 3) == 0) ? 5'd7 : 5'($urandom_range(0, 31));
      rnd_ins = {rnd_op, 4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)),
                 4'($urandom_range(0, 15)), 15'($urandom)};
      applyStimulus($urandom_range(0, 4) != 0, rnd_ins, $urandom, 1'($urandom),
                    2'($urandom), {4'($urandom_range(0, hi)), 4'($urandom_range(0, hi))},
                    {32'($urandom), 32'($urandom)}, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0);
      cyc();
    end

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 8'h00, 64'd0, 1'b0, 1'b1);
    repeat (2) cyc();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
